// File: rtl/uart_tx_wide.sv
// uart_tx_wide: wide-word UART transmitter.
// Sends DATA_W/8 back-to-back 8N1-style frames.
module uart_tx_wide #(
  parameter int DATA_W         = 128,
  parameter int CLKS_PER_BIT   = 868,
  parameter int PARITY_EN      = 0,
  parameter int PARITY_ODD     = 0,
  parameter int STOP_BITS      = 1,
  parameter int MSB_BYTE_FIRST = 1,
  localparam int NBYTES = DATA_W / 8,
  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              u_tx,
  output logic              busy,
  output logic              byte_done,
  output logic              word_done,
  output logic [IW-1:0]     byte_idx
);

  localparam int STOP_CLKS = STOP_BITS * CLKS_PER_BIT;
  localparam int CW = $clog2(STOP_CLKS + 1);

  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(STOP_CLKS - 1);
  localparam logic [CW-1:0] STOP_PRE  = CW'(STOP_CLKS - 2);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NBYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2:0]        bit_q, bit_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic              bdone_q, bdone_d;
  logic              wdone_q, wdone_d;
  logic              rdy_q, rdy_d;

  logic              bit_end;
  logic              stop_pre;
  logic              stop_end;
  logic              is_last;
  logic [7:0]        byte_d;

  assign bit_end  = (cnt_q == BIT_LAST);
  assign stop_pre = (cnt_q == STOP_PRE);
  assign stop_end = (cnt_q == STOP_LAST);
  assign is_last  = (idx_q == IDX_LAST);

  // Next-state, baud timing and registered line/flag values.
  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    idx_d   = idx_q;
    bdone_d = 1'b0;
    wdone_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (in_valid) begin
          state_d = S_START;
          sh_d    = in_data;
          idx_d   = '0;
          bit_d   = '0;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          cnt_d   = '0;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          cnt_d   = '0;
        end
      end
      S_STOP: begin
        if (stop_pre) begin
          bdone_d = 1'b1;
          wdone_d = is_last;
        end
        if (stop_end) begin
          cnt_d = '0;
          if (is_last) begin
            state_d = S_IDLE;
            idx_d   = '0;
          end else begin
            state_d = S_START;
            idx_d   = idx_q + 1'b1;
            if (MSB_BYTE_FIRST != 0) begin
              sh_d = sh_q << 8;
            end else begin
              sh_d = sh_q >> 8;
            end
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase

    if (MSB_BYTE_FIRST != 0) begin
      byte_d = sh_d[DATA_W-1 -: 8];
    end else begin
      byte_d = sh_d[7:0];
    end

    unique case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = byte_d[bit_d];
      S_PARITY: tx_d = (PARITY_ODD != 0) ? ~(^byte_d) : ^byte_d;
      default:  tx_d = 1'b1;
    endcase

    busy_d = (state_d != S_IDLE);
    rdy_d  = (state_d == S_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      sh_q    <= '0;
      cnt_q   <= '0;
      bit_q   <= '0;
      idx_q   <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      bdone_q <= 1'b0;
      wdone_q <= 1'b0;
      rdy_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      idx_q   <= idx_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      bdone_q <= bdone_d;
      wdone_q <= wdone_d;
      rdy_q   <= rdy_d;
    end
  end

  assign in_ready  = rdy_q;
  assign u_tx      = tx_q;
  assign busy      = busy_q;
  assign byte_done = bdone_q;
  assign word_done = wdone_q;
  assign byte_idx  = idx_q;

endmodule

// File: tb/tb_uart_tx_wide.sv
// tb_uart_tx_wide: scoreboard bench for uart_tx_wide.
// Three configurations run side by side.
module tb_uart_tx_wide;

  localparam int C = 4;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  // Expected line state k cycles into a word,
  // from the frame layout alone.
  function automatic void model(
    input  logic [127:0] w,
    input  int nb, pe, po, sb, msbf, k,
    output logic tx, output logic bd,
    output logic wd, output int idx);
    int fl, j, pos, bp;
    logic [127:0] s;
    logic [7:0] b;
    fl  = (9 + pe + sb) * C;
    j   = k / fl;
    pos = k % fl;
    bp  = pos / C;
    if (msbf != 0) s = w >> (8 * (nb - 1 - j));
    else           s = w >> (8 * j);
    b = s[7:0];
    if (bp == 0)                 tx = 1'b0;
    else if (bp <= 8)            tx = b[bp-1];
    else if (pe != 0 && bp == 9) tx = (po != 0) ? ~(^b) : ^b;
    else                         tx = 1'b1;
    bd  = (pos == fl - 1);
    wd  = bd && (j == nb - 1);
    idx = j;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : gi
    localparam int DW = (g == 0) ? 128 : (g == 1) ? 32 : 8;
    localparam int PE = (g == 0) ? 0 : 1;
    localparam int PO = (g == 1) ? 1 : 0;
    localparam int SB = (g == 1) ? 2 : 1;
    localparam int MF = (g == 1) ? 0 : 1;
    localparam int NB = DW / 8;
    localparam int IW = (NB > 1) ? $clog2(NB) : 1;
    localparam int WL = NB * (9 + PE + SB) * C;

    logic          rst = 1'b1;
    logic          vld = 1'b0;
    logic [127:0]  din = '0;
    logic          rdy, tx, busy, bd, wd;
    logic [IW-1:0] idx;

    uart_tx_wide #(
      .DATA_W(DW),
      .CLKS_PER_BIT(C),
      .PARITY_EN(PE),
      .PARITY_ODD(PO),
      .STOP_BITS(SB),
      .MSB_BYTE_FIRST(MF)
    ) dut (
      .clk(clk),
      .rst(rst),
      .in_data(din[DW-1:0]),
      .in_valid(vld),
      .in_ready(rdy),
      .u_tx(tx),
      .busy(busy),
      .byte_done(bd),
      .word_done(wd),
      .byte_idx(idx)
    );

    logic [127:0] q[$];
    int acc   = 0;
    bit rst_e = 1'b0;
    bit fin   = 1'b0;
    bit act   = 1'b0;
    int k     = 0;
    int nbd   = 0;
    logic [127:0] cw = '0;

    // Scoreboard push on every accept edge.
    always @(posedge clk) begin
      rst_e = rst;
      if (rst) q.delete();
      else if (vld && rdy) begin
        q.push_back(din);
        acc++;
      end
    end

    // Monitor: compare every cycle against the model.
    always @(negedge clk) begin
      logic etx, ebd, ewd;
      int eidx;
      if (rst_e) act = 1'b0;
      if (!act && q.size() > 0) begin
        cw  = q.pop_front();
        act = 1'b1;
        k   = 0;
        nbd = 0;
      end
      if (act) begin
        model(cw, NB, PE, PO, SB, MF, k, etx, ebd, ewd, eidx);
        chk($sformatf("g%0d_tx k=%0d", g, k), tx, etx);
        chk($sformatf("g%0d_bd k=%0d", g, k), bd, ebd);
        chk($sformatf("g%0d_wd k=%0d", g, k), wd, ewd);
        chk($sformatf("g%0d_idx k=%0d", g, k), idx, eidx);
        chk($sformatf("g%0d_busy k=%0d", g, k), busy, 1);
        chk($sformatf("g%0d_rdy k=%0d", g, k), rdy, 0);
        if (bd) nbd++;
        if (ewd) begin
          chk($sformatf("g%0d_nbytes", g), nbd, NB);
          act = 1'b0;
        end
        k++;
      end else begin
        chk($sformatf("g%0d_idle_tx", g), tx, 1);
        chk($sformatf("g%0d_idle_bd", g), bd, 0);
        chk($sformatf("g%0d_idle_wd", g), wd, 0);
        chk($sformatf("g%0d_idle_busy", g), busy, 0);
        chk($sformatf("g%0d_idle_rdy", g), rdy, 1);
        chk($sformatf("g%0d_idle_idx", g), idx, 0);
      end
    end

    task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
    endtask

    // Returns on the negedge of the first start-bit cycle.
    task automatic send(input logic [127:0] d, input bit hold);
      int a0;
      a0 = acc;
      @(negedge clk);
      din = d;
      vld = 1'b1;
      for (int t = 0; t < 2 * WL + 20 && acc == a0; t++)
        @(negedge clk);
      chk($sformatf("g%0d_accept", g), acc != a0, 1);
      if (!hold) vld = 1'b0;
    endtask

    task automatic wait_wd();
      int t;
      for (t = 0; t < 2 * WL && !wd; t++) @(negedge clk);
      chk($sformatf("g%0d_wd_seen", g), wd, 1);
    endtask

    task automatic drain();
      for (int t = 0; t < 4 * WL && (q.size() > 0 || act); t++)
        @(negedge clk);
      chk($sformatf("g%0d_drain", g), q.size() == 0 && !act, 1);
    endtask

    function automatic logic [127:0] rnd();
      return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic rnd_words(input int n);
      for (int i = 0; i < n; i++) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        send(rnd(), 1'b0);
      end
      drain();
    endtask

    if (g == 0) begin : s0
      initial begin
        int s, n;
        logic [127:0] w1, w2;
        do_reset();
        send(128'h00112233445566778899AABBCCDDEEFF, 1'b0);
        s = cyc;
        wait_wd();
        chk("g0_word_len", cyc - s + 1, 640);
        drain();
        rnd_words(2);
        w1 = rnd();
        w2 = rnd();
        send(w1, 1'b1);
        din = rnd();
        repeat (50) @(negedge clk);
        din = w2;
        wait_wd();
        @(negedge clk);
        chk("g0_gap_tx", tx, 1);
        chk("g0_gap_rdy", rdy, 1);
        @(negedge clk);
        vld = 1'b0;
        chk("g0_b2b_start", tx, 0);
        chk("g0_b2b_busy", busy, 1);
        drain();
        send(rnd(), 1'b0);
        for (int t = 0; t < WL && idx != 3; t++) @(negedge clk);
        chk("g0_idx3", idx, 3);
        repeat (2 * C + 1) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("g0_rst_tx", tx, 1);
        chk("g0_rst_busy", busy, 0);
        chk("g0_rst_rdy", rdy, 1);
        n = 0;
        repeat (60) begin
          @(negedge clk);
          if (bd || wd) n++;
        end
        chk("g0_rst_nopulse", n, 0);
        rnd_words(1);
        fin = 1'b1;
      end
    end else if (g == 1) begin : s1
      initial begin
        int s;
        do_reset();
        send(128'hA1B2C3D4, 1'b0);
        for (int t = 0; t < WL && !bd; t++) @(negedge clk);
        s = cyc;
        @(negedge clk);
        for (int t = 0; t < WL && !bd; t++) @(negedge clk);
        chk("g1_frame_len", cyc - s, 48);
        drain();
        send(128'h00000007, 1'b0);
        repeat (9 * C + 1) @(negedge clk);
        chk("g1_odd_par", tx, 0);
        drain();
        rnd_words(4);
        fin = 1'b1;
      end
    end else begin : s2
      initial begin
        do_reset();
        send(128'h07, 1'b0);
        repeat (9 * C + 1) @(negedge clk);
        chk("g2_even_par", tx, 1);
        wait_wd();
        chk("g2_bd_wd", bd, 1);
        @(negedge clk);
        chk("g2_rdy_after", rdy, 1);
        rnd_words(6);
        fin = 1'b1;
      end
    end
  end

  initial begin
    bit all;
    all = 1'b0;
    for (int t = 0; t < 40000 && !all; t++) begin
      @(negedge clk);
      all = gi[0].fin && gi[1].fin && gi[2].fin;
    end
    chk("all_done", all, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
